pb_click_decoder: RTL and testbench

Consumes the one-cycle release pulse from the push-button release detector and classifies each click as a single click or a double click. A double click is two releases inside a programmable window. The block also keeps a small mode register for the downstream control logic. A single click advances the mode with wrap-around, and a double click resets it to 0. Sits between the button front end and the system mode/volume control.

---
 rtl/pb_click_decoder.sv | 93 +++++++++
 tb/tb_pb_click_decoder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pb_click_decoder.sv
// Classifies button release pulses as single or double clicks and keeps a
// wrap-around mode register: single click advances it, double click clears it.
module pb_click_decoder #(
    parameter int DBL_WIN   = 25000,
    parameter int HOLD      = 10000,
    parameter int NUM_MODES = 4,
    parameter int CNT_W     = 16,
    parameter int MODE_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              released,
    input  logic              en,
    output logic              single_click,
    output logic              double_click,
    output logic [MODE_W-1:0] mode,
    output logic              busy
);

    localparam logic [CNT_W-1:0]  WIN_LAST  = CNT_W'(DBL_WIN);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD);
    localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT2   = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] m);
        return (m == MODE_LAST) ? '0 : m + MODE_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            single_click <= 1'b0;
            double_click <= 1'b0;
            mode         <= '0;
        end else begin
            single_click <= 1'b0;
            double_click <= 1'b0;
            if (!en) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (released) begin
                            state <= WAIT2;
                            cnt   <= CNT_W'(1);
                        end
                    end
                    WAIT2: begin
                        // A release on the last window cycle beats the timeout.
                        if (released) begin
                            double_click <= 1'b1;
                            mode         <= '0;
                            state        <= HOLDOFF;
                            cnt          <= CNT_W'(1);
                        end else if (cnt >= WIN_LAST) begin
                            single_click <= 1'b1;
                            mode         <= next_mode(mode);
                            state        <= IDLE;
                            cnt          <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    HOLDOFF: begin
                        if (cnt >= HOLD_LAST) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_pb_click_decoder.sv
// Directed bench for pb_click_decoder: expected click events are queued when
// releases are driven and matched against the pulses the decoder emits.
module tb_pb_click_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       released;
    logic       en;
    logic       single_click;
    logic       double_click;
    logic [1:0] mode;
    logic       busy;

    pb_click_decoder #(
        .DBL_WIN(8), .HOLD(4), .NUM_MODES(3), .CNT_W(16), .MODE_W(2)
    ) dut (
        .clk(clk), .rst(rst), .released(released), .en(en),
        .single_click(single_click), .double_click(double_click),
        .mode(mode), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic       dbl;
        logic [1:0] mode;
    } ev_t;

    ev_t        exp_q[$];
    int         cyc = 0;
    int         base = 0;
    int         total = 0;
    int         passed = 0;
    logic [1:0] exp_mode = 2'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc - base);
    endtask

    task automatic goto(input int c);
        while (cyc < base + c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_single(input int c);
        exp_mode = (exp_mode == 2'd2) ? 2'd0 : exp_mode + 2'd1;
        exp_q.push_back('{base + c, 1'b0, exp_mode});
    endtask

    task automatic expect_double(input int c);
        exp_mode = 2'd0;
        exp_q.push_back('{base + c, 1'b1, 2'd0});
    endtask

    task automatic pulse_at(input int c);
        goto(c);
        released = 1'b1;
        goto(c + 1);
        released = 1'b0;
    endtask

    // Every emitted pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && (single_click || double_click)) begin
            ev_t e;
            chk("exclusive_pulses", {31'd0, single_click & double_click}, 32'd0);
            chk("pulse_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pulse_cycle", cyc - base, e.cyc - base);
                chk("pulse_is_double", {31'd0, double_click}, {31'd0, e.dbl});
                chk("pulse_mode", {30'd0, mode}, {30'd0, e.mode});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        released = 1'b0;
        en = 1'b1;
        #1;
        chk("reset_single", {31'd0, single_click}, 32'd0);
        chk("reset_double", {31'd0, double_click}, 32'd0);
        chk("reset_mode", {30'd0, mode}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        goto(3);
        rst = 1'b0;
        goto(5);
        chk("post_reset_busy", {31'd0, busy}, 32'd0);

        // Single click: release at 10, pulse at 19.
        base = cyc;
        goto(10);
        chk("t1_busy_c10", {31'd0, busy}, 32'd0);
        released = 1'b1;
        expect_single(19);
        goto(11);
        released = 1'b0;
        chk("t1_busy_c11", {31'd0, busy}, 32'd1);
        goto(18);
        chk("t1_busy_c18", {31'd0, busy}, 32'd1);
        chk("t1_mode_c18", {30'd0, mode}, 32'd0);
        goto(19);
        chk("t1_busy_c19", {31'd0, busy}, 32'd0);
        chk("t1_mode_c19", {30'd0, mode}, 32'd1);
        goto(25);
        chk("t1_queue_empty", exp_q.size(), 32'd0);

        // Mode wrap: three isolated clicks.
        base = cyc;
        for (int i = 0; i < 3; i++) begin
            expect_single(20 * i + 9);
            pulse_at(20 * i);
        end
        goto(55);
        chk("t2_queue_empty", exp_q.size(), 32'd0);
        chk("t2_mode", {30'd0, mode}, 32'd1);

        // Second release on the last window cycle is a double click.
        base = cyc;
        pulse_at(10);
        expect_double(19);
        pulse_at(18);
        goto(19);
        chk("t3a_busy_holdoff", {31'd0, busy}, 32'd1);
        goto(30);
        chk("t3a_queue_empty", exp_q.size(), 32'd0);
        chk("t3a_mode", {30'd0, mode}, 32'd0);

        // One cycle late: single click, and that release opens a new window.
        base = cyc;
        pulse_at(10);
        expect_single(19);
        expect_single(28);
        pulse_at(19);
        goto(35);
        chk("t3b_queue_empty", exp_q.size(), 32'd0);
        chk("t3b_mode", {30'd0, mode}, 32'd2);

        // Lockout after a back-to-back double click.
        base = cyc;
        pulse_at(10);
        expect_double(12);
        pulse_at(11);
        pulse_at(13);
        goto(15);
        chk("t4_busy_c15", {31'd0, busy}, 32'd1);
        pulse_at(15);
        goto(17);
        chk("t4_busy_c17", {31'd0, busy}, 32'd0);
        expect_single(27);
        pulse_at(18);
        goto(32);
        chk("t4_queue_empty", exp_q.size(), 32'd0);
        chk("t4_mode", {30'd0, mode}, 32'd1);

        // Abort via en, with a release that must be ignored while disabled.
        base = cyc;
        pulse_at(10);
        goto(14);
        chk("t5_busy_c14", {31'd0, busy}, 32'd1);
        en = 1'b0;
        released = 1'b1;
        goto(15);
        en = 1'b1;
        released = 1'b0;
        chk("t5_busy_c15", {31'd0, busy}, 32'd0);
        chk("t5_mode_held", {30'd0, mode}, 32'd1);
        goto(19);
        chk("t5_queue_empty_c19", exp_q.size(), 32'd0);
        expect_single(29);
        pulse_at(20);
        goto(35);
        chk("t5_queue_empty", exp_q.size(), 32'd0);
        chk("t5_mode", {30'd0, mode}, 32'd2);

        // Asynchronous reset in the middle of a window.
        base = cyc;
        pulse_at(10);
        goto(13);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_mode", {30'd0, mode}, 32'd0);
        chk("t6_rst_single", {31'd0, single_click}, 32'd0);
        chk("t6_rst_double", {31'd0, double_click}, 32'd0);
        exp_mode = 2'd0;
        goto(15);
        rst = 1'b0;
        goto(30);
        chk("t6_queue_empty", exp_q.size(), 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_mode", {30'd0, mode}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
